// File: rtl/ram_arb_pkg.sv
// Shared types and reset values for the RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WR   = 2'd1,
        ARB_RD   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_WR = 1'b0,
        OWN_RD = 1'b1
    } arb_owner_e;

    localparam arb_state_e ARB_STATE_RST = ARB_IDLE;
    // Remembering the reader as last owner lets the writer win the first contention.
    localparam arb_owner_e ARB_OWNER_RST = OWN_RD;

    localparam int ARB_BURST_CNT_MIN_W = 3;

    // Width of the burst counter: enough for MAX_BURST, never below three bits.
    function automatic int burst_cnt_width(input int max_burst);
        int w;
        w = $clog2(max_burst + 1);
        return (w < ARB_BURST_CNT_MIN_W) ? ARB_BURST_CNT_MIN_W : w;
    endfunction

endpackage

// File: rtl/ram_arb_rdpipe.sv
// Read-return tracker: a RD_LAT+1 deep shift pipe of {valid, err} that lines
// up each accepted read with the cycle its RAM data appears.
module ram_arb_rdpipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    input  logic push_err,
    output logic rd_valid,
    output logic rd_err
);

    localparam int PIPE_D = RD_LAT + 1;

    logic [PIPE_D-1:0] valid_q;
    logic [PIPE_D-1:0] err_q;

    // Shift one stage per cycle; reset drops every read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= {valid_q[PIPE_D-2:0], push_valid};
            err_q   <= {err_q[PIPE_D-2:0], push_valid & push_err};
        end
    end

    assign rd_valid = valid_q[PIPE_D-1];
    assign rd_err   = valid_q[PIPE_D-1] & err_q[PIPE_D-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between a write
// client and a read client. Commands are registered, out-of-range addresses are
// accepted but flagged, read data returns after a fixed tracked latency.
// Optional feature: define RAM_ARB_BURST_EN to let the owner keep the grant for
// up to MAX_BURST consecutive cycles while it keeps requesting.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_err,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    arb_state_e state_q, state_d;
    arb_owner_e last_owner_q, last_owner_d;
    arb_owner_e prev_owner;
    logic       wr_in_range;
    logic       rd_in_range;
    logic       keep_owner;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);

    // A grant last cycle names the owner directly; after an idle gap the
    // remembered last owner decides who yields.
    assign prev_owner = (state_q == ARB_WR) ? OWN_WR :
                        (state_q == ARB_RD) ? OWN_RD : last_owner_q;

`ifdef RAM_ARB_BURST_EN
    localparam int              CNT_W   = burst_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] burst_cnt_q;
    logic             same_owner;

    assign same_owner = (wr_gnt && state_q == ARB_WR) || (rd_gnt && state_q == ARB_RD);
    assign keep_owner = (state_q != ARB_IDLE) && (burst_cnt_q < CNT_MAX);

    // Count consecutive grants of the current owner, saturating at MAX_BURST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
        end else if (wr_gnt || rd_gnt) begin
            if (!same_owner) begin
                burst_cnt_q <= CNT_W'(1);
            end else if (burst_cnt_q != CNT_MAX) begin
                burst_cnt_q <= burst_cnt_q + CNT_W'(1);
            end
        end else begin
            burst_cnt_q <= '0;
        end
    end
`else
    // Without burst support the owner never keeps the grant under contention.
    assign keep_owner = 1'b0 && (MAX_BURST > 1);
`endif

    // Grant selection and next owner/state: lone requester wins, contention alternates.
    always_comb begin
        wr_gnt       = 1'b0;
        rd_gnt       = 1'b0;
        state_d      = ARB_IDLE;
        last_owner_d = last_owner_q;
        if (wr_req && !rd_req) begin
            wr_gnt = 1'b1;
        end else if (rd_req && !wr_req) begin
            rd_gnt = 1'b1;
        end else if (wr_req && rd_req) begin
            if (keep_owner) begin
                wr_gnt = (prev_owner == OWN_WR);
                rd_gnt = (prev_owner == OWN_RD);
            end else begin
                wr_gnt = (prev_owner == OWN_RD);
                rd_gnt = (prev_owner == OWN_WR);
            end
        end
        if (wr_gnt) begin
            state_d      = ARB_WR;
            last_owner_d = OWN_WR;
        end else if (rd_gnt) begin
            state_d      = ARB_RD;
            last_owner_d = OWN_RD;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_STATE_RST;
            last_owner_q <= ARB_OWNER_RST;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Registered RAM command, issued the cycle after acceptance for one cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_err    <= 1'b0;
        end else begin
            mem_en <= (wr_gnt && wr_in_range) || (rd_gnt && rd_in_range);
            mem_we <= wr_gnt && wr_in_range;
            wr_err <= wr_gnt && !wr_in_range;
            if (wr_gnt) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (rd_gnt) begin
                mem_addr  <= rd_addr;
            end
        end
    end

    ram_arb_rdpipe #(
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (rd_gnt),
        .push_err   (!rd_in_range),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err)
    );

    assign rd_data = (rd_valid && !rd_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios followed by
// randomized requests, all checked against a transaction-level reference model
// and a behavioural RAM with RD_LAT read latency.
module tb_ram_port_arbiter;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int DEPTH     = 12;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 4;
    localparam int HORIZON   = 2048;
    localparam int WORDS     = 1 << ADDR_W;
`ifdef RAM_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_gnt;
    logic              wr_err;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .wr_err    (wr_err),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Behavioural single-port RAM; idle read stages carry junk on purpose.
    logic [DATA_W-1:0] ram [0:WORDS-1];
    logic [DATA_W-1:0] ram_pipe [0:RD_LAT-1];
    assign mem_rdata = ram_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        ram_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : DATA_W'($urandom);
        for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end

    // Reference model: expected per-cycle outputs scheduled from accepted transactions.
    bit                exp_en    [0:HORIZON-1];
    bit                exp_we    [0:HORIZON-1];
    logic [ADDR_W-1:0] exp_addr  [0:HORIZON-1];
    logic [DATA_W-1:0] exp_wdata [0:HORIZON-1];
    bit                exp_werr  [0:HORIZON-1];
    bit                exp_rv    [0:HORIZON-1];
    bit                exp_rerr  [0:HORIZON-1];
    logic [DATA_W-1:0] exp_rdata [0:HORIZON-1];
    bit                exp_rknown[0:HORIZON-1];
    logic [DATA_W-1:0] model_mem  [0:WORDS-1];
    bit                model_known[0:WORDS-1];
    bit                last_wr;
    bit                prev_gnt;
    int                run_len;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < HORIZON; i++) begin
            exp_en[i] = 0; exp_we[i] = 0; exp_werr[i] = 0;
            exp_rv[i] = 0; exp_rerr[i] = 0; exp_rknown[i] = 0;
            exp_addr[i] = '0; exp_wdata[i] = '0; exp_rdata[i] = '0;
        end
        for (int i = 0; i < WORDS; i++) model_known[i] = 0;
        last_wr  = 0;
        prev_gnt = 0;
        run_len  = 0;
        cyc      = 0;
    endtask

    // Async reset: everything must read 0 while held; model forgets in-flight work.
    task automatic doReset();
        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        #2;
        checkOutput("rst_wr_gnt", wr_gnt, 0);
        checkOutput("rst_rd_gnt", rd_gnt, 0);
        checkOutput("rst_wr_err", wr_err, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_rd_err", rd_err, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clearModel();
    endtask

    // Drive one cycle of requests, check every output mid-cycle, advance the model.
    task automatic applyStimulus(input logic wq, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd, input logic rq,
                                 input logic [ADDR_W-1:0] ra,
                                 output logic wg_o, output logic rg_o);
        bit ew, er;
        int t;
        wr_req = wq; wr_addr = wa; wr_data = wd;
        rd_req = rq; rd_addr = ra;
        @(negedge clk);
        ew = 0; er = 0;
        if (wq && !rq) ew = 1;
        else if (rq && !wq) er = 1;
        else if (wq && rq) begin
            if (BURST_EN && prev_gnt && run_len < MAX_BURST) begin
                ew = last_wr; er = !last_wr;
            end else begin
                ew = !last_wr; er = last_wr;
            end
        end
        checkOutput("wr_gnt", wr_gnt, ew);
        checkOutput("rd_gnt", rd_gnt, er);
        checkOutput("mem_en", mem_en, exp_en[cyc]);
        checkOutput("mem_we", mem_we, exp_we[cyc]);
        if (exp_en[cyc]) checkOutput("mem_addr", mem_addr, exp_addr[cyc]);
        if (exp_we[cyc]) checkOutput("mem_wdata", mem_wdata, exp_wdata[cyc]);
        checkOutput("wr_err", wr_err, exp_werr[cyc]);
        checkOutput("rd_valid", rd_valid, exp_rv[cyc]);
        checkOutput("rd_err", rd_err, exp_rerr[cyc]);
        if (exp_rv[cyc] && exp_rknown[cyc]) checkOutput("rd_data", rd_data, exp_rdata[cyc]);

        if (ew) begin
            if (int'(wa) < DEPTH) begin
                exp_en[cyc+1] = 1; exp_we[cyc+1] = 1;
                exp_addr[cyc+1] = wa; exp_wdata[cyc+1] = wd;
                model_mem[wa] = wd; model_known[wa] = 1;
            end else begin
                exp_werr[cyc+1] = 1;
            end
        end
        if (er) begin
            t = cyc + 1 + RD_LAT;
            exp_rv[t] = 1;
            if (int'(ra) < DEPTH) begin
                exp_en[cyc+1] = 1; exp_addr[cyc+1] = ra;
                exp_rdata[t] = model_mem[ra]; exp_rknown[t] = model_known[ra];
            end else begin
                exp_rerr[t] = 1; exp_rdata[t] = '0; exp_rknown[t] = 1;
            end
        end
        if (ew || er) begin
            run_len  = (prev_gnt && (ew == last_wr)) ? run_len + 1 : 1;
            last_wr  = ew;
            prev_gnt = 1;
        end else begin
            prev_gnt = 0;
        end
        wg_o = ew;
        rg_o = er;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic g1, g2;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, g1, g2);
    endtask

    initial begin
        logic              g1, g2;
        logic              pw, pr;
        logic [ADDR_W-1:0] wa, ra;
        logic [DATA_W-1:0] wd;

        #1;
        doReset();

        // Read of addr 3 in flight, then reset before its data returns.
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd3, g1, g2);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, g1, g2);
        doReset();
        idle(RD_LAT + 3);

        // Contention straight out of reset: both held for six cycles.
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'd7, 8'h3C, 1'b1, 4'd8, g1, g2);
        idle(RD_LAT + 2);

        // Write 5 alone, then read it back.
        applyStimulus(1'b1, 4'd5, 8'hA5, 1'b0, '0, g1, g2);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd5, g1, g2);
        idle(RD_LAT + 2);

        // Out of range write 13 and read 15.
        applyStimulus(1'b1, 4'd13, 8'h77, 1'b0, '0, g1, g2);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd15, g1, g2);
        idle(RD_LAT + 2);

        // Fill addresses 0..3, then back-to-back reads.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, ADDR_W'(i), DATA_W'(8'h10 + i), 1'b0, '0, g1, g2);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, '0, '0, 1'b1, ADDR_W'(i), g1, g2);
        idle(RD_LAT + 2);

        // Randomized clients that hold their request until granted.
        pw = 0; pr = 0; wa = '0; ra = '0; wd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pw && $urandom_range(0, 3) != 0) begin
                pw = 1; wa = ADDR_W'($urandom_range(0, WORDS - 1)); wd = DATA_W'($urandom);
            end
            if (!pr && $urandom_range(0, 3) != 0) begin
                pr = 1; ra = ADDR_W'($urandom_range(0, WORDS - 1));
            end
            applyStimulus(pw, wa, wd, pr, ra, g1, g2);
            if (g1) pw = 0;
            if (g2) pr = 0;
        end
        idle(RD_LAT + 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
